// File: rtl/adc_pkg.sv
// Shared defaults, record types and output-holding state encoding for the
// ADC channel averager.
package adc_pkg;

    localparam int ADC_DATA_W   = 12;
    localparam int ADC_CH_W     = 3;
    localparam int ADC_AVG_LOG2 = 4;

    typedef struct packed {
        logic [ADC_CH_W-1:0]   ch;
        logic [ADC_DATA_W-1:0] data;
    } adc_sample_t;

    typedef struct packed {
        logic [ADC_CH_W-1:0]   ch;
        logic [ADC_DATA_W-1:0] avg;
    } adc_result_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/adc_ch_accum.sv
// Single-channel window accumulator with terminal-count detect.
// With ADC_CH_MINMAX_EN the window minimum and maximum are tracked too.
module adc_ch_accum
    import adc_pkg::*;
#(
    parameter int AVG_LOG2 = ADC_AVG_LOG2,
    parameter int DATA_W   = ADC_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              sample_en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              done_o,
    output logic [DATA_W-1:0] avg_o
`ifdef ADC_CH_MINMAX_EN
    ,
    output logic [DATA_W-1:0] min_o,
    output logic [DATA_W-1:0] max_o
`endif
);

    localparam int ACC_W = DATA_W + AVG_LOG2;

    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_d;
    logic [AVG_LOG2-1:0] cnt_q;
    logic                terminal;

    // acc_d includes the sample being accepted, so the emitted average covers the full window
    assign acc_d    = acc_q + ACC_W'(data_i);
    assign terminal = (cnt_q == {AVG_LOG2{1'b1}});
    assign done_o   = sample_en_i && terminal;
    assign avg_o    = acc_d[ACC_W-1:AVG_LOG2];

`ifdef ADC_CH_MINMAX_EN
    logic [DATA_W-1:0] min_q;
    logic [DATA_W-1:0] max_q;

    assign min_o = (data_i < min_q) ? data_i : min_q;
    assign max_o = (data_i > max_q) ? data_i : max_q;
`endif

    always_ff @(posedge clock) begin
        if (reset || clear_i) begin
            acc_q <= '0;
            cnt_q <= '0;
`ifdef ADC_CH_MINMAX_EN
            min_q <= '1;
            max_q <= '0;
`endif
        end else if (sample_en_i) begin
            if (terminal) begin
                acc_q <= '0;
                cnt_q <= '0;
`ifdef ADC_CH_MINMAX_EN
                min_q <= '1;
                max_q <= '0;
`endif
            end else begin
                acc_q <= acc_d;
                cnt_q <= cnt_q + AVG_LOG2'(1);
`ifdef ADC_CH_MINMAX_EN
                min_q <= min_o;
                max_q <= max_o;
`endif
            end
        end
    end

endmodule

// File: rtl/adc_ch_averager.sv
// Per-channel boxcar averager of 2**AVG_LOG2 samples with a one-deep result register
// and a readable result bank. Define ADC_CH_MINMAX_EN to add window min/max tracking.
//
// state     | meaning
// OUT_EMPTY | no result pending downstream
// OUT_FULL  | out_ch/out_avg hold a result until out_ready
module adc_ch_averager
    import adc_pkg::*;
#(
    parameter int AVG_LOG2 = ADC_AVG_LOG2,
    parameter int DATA_W   = ADC_DATA_W,
    parameter int CH_W     = ADC_CH_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] out_avg,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [DATA_W-1:0] rd_avg
`ifdef ADC_CH_MINMAX_EN
    ,
    output logic [DATA_W-1:0] rd_min,
    output logic [DATA_W-1:0] rd_max
`endif
);

    localparam int N_CH = 2**CH_W;

    out_state_e        state_q;
    logic [CH_W-1:0]   out_ch_q;
    logic [DATA_W-1:0] out_avg_q;
    logic [DATA_W-1:0] bank_avg_q [N_CH];
    logic [DATA_W-1:0] avg_vec    [N_CH];
    logic [N_CH-1:0]   done_vec;
    logic              accept;
    logic              emit;

`ifdef ADC_CH_MINMAX_EN
    logic [DATA_W-1:0] bank_min_q [N_CH];
    logic [DATA_W-1:0] bank_max_q [N_CH];
    logic [DATA_W-1:0] min_vec    [N_CH];
    logic [DATA_W-1:0] max_vec    [N_CH];

    assign rd_min = bank_min_q[rd_ch];
    assign rd_max = bank_max_q[rd_ch];
`endif

    assign out_valid = (state_q == OUT_FULL);
    assign out_ch    = out_ch_q;
    assign out_avg   = out_avg_q;
    assign rd_avg    = bank_avg_q[rd_ch];
    assign in_ready  = !reset && !clear && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    // only the addressed channel can be enabled, so at most one done bit is set
    assign emit      = |done_vec;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        adc_ch_accum #(
            .AVG_LOG2 (AVG_LOG2),
            .DATA_W   (DATA_W)
        ) u_accum (
            .clock       (clock),
            .reset       (reset),
            .clear_i     (clear),
            .sample_en_i (accept && (in_ch == CH_W'(g))),
            .data_i      (in_data),
            .done_o      (done_vec[g]),
            .avg_o       (avg_vec[g])
`ifdef ADC_CH_MINMAX_EN
            ,
            .min_o       (min_vec[g]),
            .max_o       (max_vec[g])
`endif
        );
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            state_q   <= OUT_EMPTY;
            out_ch_q  <= '0;
            out_avg_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                bank_avg_q[i] <= '0;
`ifdef ADC_CH_MINMAX_EN
                bank_min_q[i] <= '0;
                bank_max_q[i] <= '0;
`endif
            end
        end else if (emit) begin
            state_q             <= OUT_FULL;
            out_ch_q            <= in_ch;
            out_avg_q           <= avg_vec[in_ch];
            bank_avg_q[in_ch]   <= avg_vec[in_ch];
`ifdef ADC_CH_MINMAX_EN
            bank_min_q[in_ch]   <= min_vec[in_ch];
            bank_max_q[in_ch]   <= max_vec[in_ch];
`endif
        end else if (out_valid && out_ready) begin
            state_q <= OUT_EMPTY;
        end
    end

endmodule
